rx_sink: RTL and testbench
==========================

RX_SINK -- requirements
Module: rx_sink

Interface
REQ-001 Parameter N, default 4: data word width in bits; legal range 2..16.
REQ-002 Parameter DEPTH, default 4: FIFO depth in words; power of two, legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled only on the rising edge of clk.
REQ-005 valid_i  input  1  upstream word-valid, driven by the transmitter stage.
REQ-006 data_i  input  N  upstream data word, qualified by valid_i.
REQ-007 ready_o  output  1  asserted when rx_sink can accept a word this cycle.
REQ-008 sout  output  1  serial data bit, LSB first.
REQ-009 sout_valid  output  1  asserted while sout carries a valid bit.
REQ-010 done_o  output  1  one-cycle pulse after the last bit of a word.
REQ-011 level_o  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-012 Handshake: a word is accepted on a rising edge where valid_i=1 and ready_o=1; no other condition accepts a word.
REQ-013 ready_o = (level_o != DEPTH), derived from registered occupancy only; it does not depend on valid_i or on a same-cycle pop.
REQ-014 When full, a word is refused even if a pop occurs in the same cycle; upstream holds valid_i and data_i until accepted.
REQ-015 The FIFO preserves order; the read and write pointers wrap modulo DEPTH without loss.
REQ-016 level_o updates by +1 on a push only, -1 on a pop only, and 0 on a simultaneous push and pop.
REQ-017 The serializer FSM has states IDLE, SHIFT and DONE.
REQ-018 IDLE: if level_o != 0, pop the head word into shift register sreg, clear bit counter bcnt, and go to SHIFT; otherwise stay in IDLE.
REQ-019 SHIFT: sout_valid=1 and sout=sreg[0]; on each edge sreg shifts right by one and bcnt increments; when bcnt==N-1, go to DONE.
REQ-020 DONE: done_o=1 for exactly one cycle, then go to IDLE.
REQ-021 In IDLE and DONE: sout_valid=0 and sout=0.
REQ-022 Latency: a word accepted at edge E0 into an empty FIFO with the FSM in IDLE is popped at E1; its first bit is valid in the cycle after E1.
REQ-023 Each word occupies exactly N SHIFT cycles plus 1 DONE cycle plus at least 1 IDLE cycle, so throughput is one word per N+2 cycles.
REQ-024 A word pushed into an empty FIFO is not bypassed; it becomes poppable only on the next cycle.
REQ-025 An illegal state encoding returns the FSM to IDLE on the next edge with all outputs deasserted.
REQ-026 All outputs are driven in every state; the design contains no latches.

Reset
REQ-027 While rst=0 at a rising edge, the following are cleared: FSM=IDLE, read/write pointers=0, level_o=0, sreg=0, bcnt=0.
REQ-028 In the cycle after reset: ready_o=1, sout=0, sout_valid=0, done_o=0.
REQ-029 Reset asserted mid-SHIFT aborts the word and discards all FIFO contents; no done_o pulse is produced.

Structure
REQ-030 Package rx_sink_pkg holds the FSM state enum (IDLE, SHIFT, DONE) and default constants for N and DEPTH.
REQ-031 The FIFO is a separate sub-module sync_fifo, parameterised by N and DEPTH, exposing push, pop, full, empty and level.
REQ-032 rx_sink instantiates sync_fifo once and contains only the serializer FSM and the handshake logic.

Verification
REQ-033 Reset check: hold rst=0 for 2 cycles -> ready_o=1, level_o=0, sout_valid=0, done_o=0.
REQ-034 Single word: push data_i=4'b0101 into an idle, empty block -> sout=1,0,1,0 on 4 consecutive sout_valid cycles starting 2 edges after acceptance, then done_o=1 for one cycle.
REQ-035 Fill: hold valid_i=1 with words 1..6 -> ready_o=0 when level_o=4; all 6 words serialize in order with no loss or duplication.
REQ-036 Full plus pop: with the FIFO full and a pop occurring, present valid_i=1 -> word not accepted that cycle; accepted on the next cycle.
REQ-037 Reset mid-operation: assert rst=0 during the 2nd SHIFT bit of a word, with 2 words queued -> sout_valid=0 next cycle, level_o=0, no done_o, and no stale words afterwards.
REQ-038 Back-to-back: two queued words -> exactly one IDLE cycle between the DONE of word 1 and the first SHIFT of word 2.

Source files
------------

// File: rtl/rx_sink_pkg.sv
// Shared definitions for rx_sink: serializer state encoding and default sizing.
package rx_sink_pkg;

    localparam int N_DEFAULT     = 4;
    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; push is ignored when full, pop when empty.
module sync_fifo
    import rx_sink_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [N-1:0]             din,
    output logic [N-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign dout  = mem[rptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/rx_sink.sv
// Accepts words over a valid/ready handshake into a FIFO and serializes each
// one LSB first, followed by a one-cycle done pulse.
module rx_sink
    import rx_sink_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic [N-1:0]             data_i,
    output logic                     ready_o,
    output logic                     sout,
    output logic                     sout_valid,
    output logic                     done_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int BW = $clog2(N);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]    state;
    logic [N-1:0]  sreg;
    logic [BW-1:0] bcnt;
    logic [N-1:0]  head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Ready comes from registered occupancy only, so a full FIFO refuses
    // a word even when the serializer pops in the same cycle.
    assign ready_o = !full;
    assign push    = valid_i && ready_o;
    assign pop     = (state == ST_IDLE) && !empty;

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (data_i),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            sreg  <= '0;
            bcnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        sreg  <= head;
                        bcnt  <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sreg <= {1'b0, sreg[N-1:1]};
                    bcnt <= bcnt + BW'(1);
                    if (bcnt == BW'(N - 1)) state <= ST_DONE;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign sout_valid = (state == ST_SHIFT);
    assign sout       = sout_valid & sreg[0];
    assign done_o     = (state == ST_DONE);

endmodule

// File: tb/tb_rx_sink.sv
// Directed bench for rx_sink: a queue-based model is compared every cycle,
// plus literal expectations for reset, latency, fill, full+pop, reset abort and gap.
module tb_rx_sink;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_i = 1'b0;
    logic [N-1:0]  data_i = '0;
    logic          ready_o;
    logic          sout;
    logic          sout_valid;
    logic          done_o;
    logic [LW-1:0] level_o;

    rx_sink #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .ready_o    (ready_o),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done_o     (done_o),
        .level_o    (level_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: queued words, word being sent, and its position in the frame
    // (-1 = idle, 0..N-1 = bit index, N = done cycle).
    int m_q[$];
    int m_cur   = 0;
    int m_phase = -1;
    bit chk_en  = 1'b0;

    int obs[$];
    int obs_word = 0;
    int obs_n    = 0;
    int max_level = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        bit acc;
        bit popping;
        if (!rst) begin
            m_q.delete();
            m_phase = -1;
            return;
        end
        acc     = valid_i && (m_q.size() != DEPTH);
        popping = (m_phase < 0) && (m_q.size() > 0);
        if (popping) begin
            m_cur   = m_q.pop_front();
            m_phase = 0;
        end else if (m_phase == N) begin
            m_phase = -1;
        end else if (m_phase >= 0) begin
            m_phase = m_phase + 1;
        end
        if (acc) m_q.push_back(int'(data_i));
    endfunction

    task automatic tick();
        int e_sv;
        int e_sout;
        model_step();
        @(posedge clk);
        @(negedge clk);
        if (!rst) begin
            obs_word = 0;
            obs_n    = 0;
        end else if (sout_valid) begin
            obs_word = obs_word | (int'(sout) << obs_n);
            obs_n++;
        end else if (done_o) begin
            obs.push_back(obs_word);
            obs_word = 0;
            obs_n    = 0;
        end
        if (int'(level_o) > max_level) max_level = int'(level_o);
        if (chk_en) begin
            e_sv   = (m_phase >= 0 && m_phase < N) ? 1 : 0;
            e_sout = e_sv ? ((m_cur >> m_phase) & 1) : 0;
            check("cyc_ready", int'(ready_o), (m_q.size() != DEPTH) ? 1 : 0);
            check("cyc_level", int'(level_o), m_q.size());
            check("cyc_sout_valid", int'(sout_valid), e_sv);
            check("cyc_sout", int'(sout), e_sout);
            check("cyc_done", int'(done_o), (m_phase == N) ? 1 : 0);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            tick();
            n++;
        end
        if (!done_o) check(name, 0, 1);
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n = 0;
        while ((m_phase >= 0 || m_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        tick();
        if (m_phase >= 0 || m_q.size() > 0) check(name, 0, 1);
    endtask

    int fullpop_hits = 0;

    // Holds valid_i until the word is taken; also pins the full+pop refusal.
    task automatic send(input int word);
        bit accepted = 1'b0;
        bit fp_prev  = 1'b0;
        bit fp_now;
        int n = 0;
        valid_i = 1'b1;
        data_i  = N'(word);
        while (!accepted && n < 50) begin
            accepted = ready_o;
            fp_now   = !ready_o && (m_phase < 0) && (m_q.size() > 0);
            tick();
            n++;
            if (fp_now) begin
                check("fullpop_refused_level", int'(level_o), DEPTH - 1);
                check("fullpop_ready_after", int'(ready_o), 1);
                fullpop_hits++;
            end
            if (fp_prev && accepted) check("fullpop_accept_next", int'(level_o), DEPTH);
            fp_prev = fp_now;
        end
        if (!accepted) check("send_timeout", 0, 1);
    endtask

    initial begin
        int gap;
        int cnt_done;
        int cnt_sv;

        // Reset for two cycles
        rst = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b1;
        check("reset_ready", int'(ready_o), 1);
        check("reset_level", int'(level_o), 0);
        check("reset_sout_valid", int'(sout_valid), 0);
        check("reset_done", int'(done_o), 0);
        check("reset_sout", int'(sout), 0);
        tick();

        // Single word 4'b0101
        valid_i = 1'b1;
        data_i  = 4'b0101;
        tick();
        valid_i = 1'b0;
        check("single_level_after_accept", int'(level_o), 1);
        check("single_not_bypassed", int'(sout_valid), 0);
        tick();
        check("single_b0_valid", int'(sout_valid), 1);
        check("single_b0", int'(sout), 1);
        check("single_popped_level", int'(level_o), 0);
        tick();
        check("single_b1", int'(sout), 0);
        tick();
        check("single_b2", int'(sout), 1);
        tick();
        check("single_b3", int'(sout), 0);
        check("single_b3_valid", int'(sout_valid), 1);
        tick();
        check("single_done", int'(done_o), 1);
        check("single_done_sv", int'(sout_valid), 0);
        tick();
        check("single_done_pulse_end", int'(done_o), 0);
        tick();

        // Fill with words 1..6 held back-to-back
        obs.delete();
        max_level = 0;
        for (int w = 1; w <= 6; w++) send(w);
        valid_i = 1'b0;
        wait_drained("fill_drain_timeout", 200);
        check("fill_max_level", max_level, DEPTH);
        check("fill_fullpop_seen", fullpop_hits, 1);
        check("fill_count", obs.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < obs.size()) check("fill_order", obs[i], i + 1);
        end

        // Back-to-back: exactly one idle cycle between frames
        obs.delete();
        valid_i = 1'b1;
        data_i  = 4'hA;
        tick();
        data_i  = 4'h3;
        tick();
        valid_i = 1'b0;
        wait_done("b2b_first_done_timeout", 20);
        gap = 0;
        tick();
        while (!sout_valid && gap < 10) begin
            gap++;
            tick();
        end
        check("b2b_idle_gap", gap, 1);
        wait_drained("b2b_drain_timeout", 40);
        check("b2b_count", obs.size(), 2);
        if (obs.size() == 2) begin
            check("b2b_word0", obs[0], 4'hA);
            check("b2b_word1", obs[1], 4'h3);
        end

        // Reset during the 2nd bit with two words queued
        obs.delete();
        valid_i = 1'b1;
        data_i  = 4'h9;
        tick();
        data_i  = 4'h6;
        tick();
        data_i  = 4'hC;
        tick();
        valid_i = 1'b0;
        check("abort_pre_sv", int'(sout_valid), 1);
        check("abort_pre_bit1", int'(sout), 0);
        check("abort_pre_level", int'(level_o), 2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_sv", int'(sout_valid), 0);
        check("abort_level", int'(level_o), 0);
        check("abort_done", int'(done_o), 0);
        check("abort_ready", int'(ready_o), 1);
        cnt_done = 0;
        cnt_sv   = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cnt_done += int'(done_o);
            cnt_sv   += int'(sout_valid);
        end
        check("abort_no_done", cnt_done, 0);
        check("abort_no_stale", cnt_sv, 0);
        check("abort_no_words", obs.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
